// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory responder for the MEM-stage
// load/store port. It accepts one request at a time, holds the pipeline with
// `stall` for LATENCY wait states, and then completes with a one-cycle
// `ready` pulse.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   mem_read          - load request (level, held until ready)
//   mem_write         - store request (level, held until ready; wins over read)
//   addr, write_data  - byte address and store data, latched at acceptance
//   read_data         - registered load result; holds until the next read
//   stall             - combinational pipeline freeze
//   ready, misaligned - registered completion pulses (DONE state only)
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        stall,
    output logic        ready,
    output logic        misaligned
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]    state;
    logic [CW-1:0] count;
    logic [31:0]   lat_addr;
    logic [31:0]   lat_wdata;
    logic          lat_write;   // 0 means the latched op is a read

    logic [31:0]   mem [DEPTH_WORDS];

    logic          req;
    logic          access;
    logic          lat_mis;
    logic          mem_we;
    logic [AW-1:0] widx;
    logic          unused_addr_bits;

    assign req     = mem_read | mem_write;
    assign access  = (state == BUSY) && (count == '0);
    assign lat_mis = (lat_addr[1:0] != 2'b00);
    // Upper address bits are dropped so out-of-range addresses wrap.
    assign widx    = lat_addr[AW+1:2];
    assign unused_addr_bits = ^lat_addr[31:AW+2];

    // Reset in the final BUSY cycle must abort the pending store.
    assign mem_we  = access & lat_write & ~lat_mis & ~reset;

    assign stall   = ~reset & (((state == IDLE) & req) | (state == BUSY));

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            count      <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            lat_write  <= 1'b0;
            read_data  <= '0;
            ready      <= 1'b0;
            misaligned <= 1'b0;
        end else begin
            ready      <= 1'b0;
            misaligned <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        lat_addr  <= addr;
                        lat_wdata <= write_data;
                        lat_write <= mem_write;
                        count     <= CNT_INIT;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end else begin
                        state      <= DONE;
                        ready      <= 1'b1;
                        misaligned <= lat_mis;
                        if (!lat_write)
                            read_data <= lat_mis ? 32'd0 : mem[widx];
                    end
                end
                // A request still held here is deliberately not re-accepted.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[widx] <= lat_wdata;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder (DEPTH_WORDS=256, LATENCY=2).
// Expected results come from a small memory model and go through a scoreboard queue.
module tb_dmem_responder;

    localparam int LAT = 2;

    logic        clk = 1'b0;
    logic        reset, mem_read, mem_write, stall, ready, misaligned;
    logic [31:0] addr, write_data, read_data;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(LAT)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .addr(addr), .write_data(write_data), .read_data(read_data),
        .stall(stall), .ready(ready), .misaligned(misaligned)
    );

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] model_mem [int];
    logic [31:0] model_rd;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;

    // Array-write monitor: mem_we is high for exactly one cycle per store.
    always @(negedge clk) if (dut.mem_we === 1'b1) wr_cnt++;

    function automatic void predict(input logic wr, input logic rd, input logic [31:0] a,
                                    input logic [31:0] d, input string nm);
        exp_t e;
        int   idx;
        idx   = int'(a[9:2]);
        e.mis = (a[1:0] != 2'b00);
        if (e.mis) begin
            if (!wr && rd) model_rd = 32'd0;
        end else if (wr) begin
            model_mem[idx] = d;
        end else begin
            model_rd = model_mem[idx];
        end
        e.rd   = model_rd;
        e.name = nm;
        exp_q.push_back(e);
    endfunction

    // Drive one request and observe it to completion; only reports what it saw.
    task automatic issue(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input bit hold, output int sc,
                         output logic rs, output logic [31:0] rdat, output logic mis,
                         output bit to);
        sc = 0; to = 1'b1; rs = 1'bx; rdat = 'x; mis = 1'bx;
        @(negedge clk);
        mem_write = wr; mem_read = rd; addr = a; write_data = d;
        #1;
        for (int k = 0; k < 20; k++) begin
            if (ready === 1'b1) begin
                to = 1'b0; rs = stall; rdat = read_data; mis = misaligned;
                break;
            end
            if (stall === 1'b1) sc++;
            @(negedge clk); #1;
        end
        if (!hold) begin mem_write = 1'b0; mem_read = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 1'b1; mem_write = 1'b0; addr = 32'h10; write_data = 0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        checks++;
        if ({ready, misaligned} !== 2'b00) begin
            errors++; $display("FAIL reset_pulses: ready=%b misaligned=%b want 0/0", ready, misaligned);
        end
        checks++;
        if (read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", read_data); end
        mem_read = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_rd = 32'd0;
    endtask

    task automatic test_write_read();
        logic [31:0] ta [2] = '{32'h10, 32'h10};
        logic [31:0] td [2] = '{32'hDEADBEEF, 32'h0};
        logic        tw [2] = '{1'b1, 1'b0};
        int sc; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            predict(tw[i], !tw[i], ta[i], td[i], tw[i] ? "wr_10" : "rd_10");
            issue(tw[i], !tw[i], ta[i], td[i], 1'b0, sc, rs, rdat, mis, to);
            e = exp_q.pop_front();
            checks++;
            if (to || sc !== LAT + 1 || rs !== 1'b0) begin
                errors++;
                $display("FAIL %s timing: stall_cycles=%0d stall_at_ready=%b timeout=%0d want %0d/0/0",
                         e.name, sc, rs, to, LAT + 1);
            end
            checks++;
            if (rdat !== e.rd) begin errors++; $display("FAIL %s rdata: got %h want %h", e.name, rdat, e.rd); end
            checks++;
            if (mis !== e.mis) begin errors++; $display("FAIL %s misaligned: got %b want %b", e.name, mis, e.mis); end
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] ta [3] = '{32'h13, 32'h11, 32'h10};
        logic        tw [3] = '{1'b0, 1'b1, 1'b0};
        int sc; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        for (int i = 0; i < 3; i++) begin
            predict(tw[i], !tw[i], ta[i], 32'hFFFF_0000, $sformatf("mis_%0d", i));
            issue(tw[i], !tw[i], ta[i], 32'hFFFF_0000, 1'b0, sc, rs, rdat, mis, to);
            e = exp_q.pop_front();
            checks++;
            if (to || sc !== LAT + 1) begin
                errors++; $display("FAIL %s timing: stall_cycles=%0d timeout=%0d want %0d/0", e.name, sc, to, LAT + 1);
            end
            checks++;
            if (rdat !== e.rd) begin errors++; $display("FAIL %s rdata: got %h want %h", e.name, rdat, e.rd); end
            checks++;
            if (mis !== e.mis) begin errors++; $display("FAIL %s misaligned: got %b want %b", e.name, mis, e.mis); end
        end
    endtask

    task automatic test_simultaneous();
        int sc; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            // First pass: read+write together (write wins); second: read back.
            predict(i == 0, 1'b1, 32'h20, 32'd5, i == 0 ? "rw_20" : "rd_20");
            issue(i == 0, 1'b1, 32'h20, 32'd5, 1'b0, sc, rs, rdat, mis, to);
            e = exp_q.pop_front();
            checks++;
            if (to || rdat !== e.rd) begin
                errors++; $display("FAIL %s rdata: got %h want %h timeout=%0d", e.name, rdat, e.rd, to);
            end
            checks++;
            if (mis !== e.mis) begin errors++; $display("FAIL %s misaligned: got %b want %b", e.name, mis, e.mis); end
        end
    endtask

    task automatic test_wrap();
        logic [31:0] ta [2] = '{32'h400, 32'h000};
        int sc; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        for (int i = 0; i < 2; i++) begin
            predict(i == 0, i != 0, ta[i], 32'd7, i == 0 ? "wr_400" : "rd_000");
            issue(i == 0, i != 0, ta[i], 32'd7, 1'b0, sc, rs, rdat, mis, to);
            e = exp_q.pop_front();
            checks++;
            if (to || rdat !== e.rd) begin
                errors++; $display("FAIL %s rdata: got %h want %h timeout=%0d", e.name, rdat, e.rd, to);
            end
        end
    endtask

    task automatic test_reset_mid();
        int sc; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        predict(1'b1, 1'b0, 32'h8, 32'h11, "wr_8");
        issue(1'b1, 1'b0, 32'h8, 32'h11, 1'b0, sc, rs, rdat, mis, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin errors++; $display("FAIL %s timeout: no ready", e.name); end
        // Store 0x55 to 0x8, reset lands in the final BUSY cycle.
        @(negedge clk);
        mem_write = 1'b1; addr = 32'h8; write_data = 32'h55;
        repeat (LAT) @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
        @(negedge clk); #1;
        checks++;
        if ({ready, misaligned} !== 2'b00 || read_data !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs: ready=%b misaligned=%b rdata=%h want 0/0/0", ready, misaligned, read_data);
        end
        mem_write = 1'b0; reset = 1'b0; model_rd = 32'd0;
        @(negedge clk); #1;
        checks++;
        if (stall !== 1'b0 || ready !== 1'b0) begin
            errors++; $display("FAIL rst_mid_idle: stall=%b ready=%b want 0/0", stall, ready);
        end
        predict(1'b0, 1'b1, 32'h8, 32'h0, "rd_8_after_rst");
        issue(1'b0, 1'b1, 32'h8, 32'h0, 1'b0, sc, rs, rdat, mis, to);
        e = exp_q.pop_front();
        checks++;
        if (to || rdat !== e.rd) begin
            errors++; $display("FAIL %s rdata: got %h want %h timeout=%0d", e.name, rdat, e.rd, to);
        end
    endtask

    task automatic test_back_to_back();
        int sc, w0, rdy; logic rs, mis; logic [31:0] rdat; bit to; exp_t e;
        w0 = wr_cnt;
        predict(1'b1, 1'b0, 32'h30, 32'h99, "held_wr_30");
        issue(1'b1, 1'b0, 32'h30, 32'h99, 1'b1, sc, rs, rdat, mis, to);
        e = exp_q.pop_front();
        checks++;
        if (to || sc !== LAT + 1) begin
            errors++; $display("FAIL %s timing: stall_cycles=%0d timeout=%0d want %0d/0", e.name, sc, to, LAT + 1);
        end
        // Request stays held across the DONE edge; next cycle issues a read.
        @(negedge clk);
        mem_write = 1'b0; mem_read = 1'b1; addr = 32'h30;
        #1;
        checks++;
        if (stall !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL b2b_accept: stall=%b ready=%b want 1/0", stall, ready);
        end
        predict(1'b0, 1'b1, 32'h30, 32'h0, "b2b_rd_30");
        sc = 1; to = 1'b1; rdy = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            if (ready === 1'b1) begin to = 1'b0; rdat = read_data; break; end
            if (stall === 1'b1) sc++;
        end
        mem_read = 1'b0;
        e = exp_q.pop_front();
        checks++;
        if (to || sc !== LAT + 1 || rdat !== e.rd) begin
            errors++;
            $display("FAIL %s: rdata=%h stall_cycles=%0d timeout=%0d want %h/%0d/0", e.name, rdat, sc, to, e.rd, LAT + 1);
        end
        repeat (4) begin
            @(negedge clk); #1;
            if (ready === 1'b1) rdy++;
        end
        checks++;
        if (rdy !== 0) begin errors++; $display("FAIL b2b_extra_ready: got %0d pulses want 0", rdy); end
        checks++;
        if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL held_write_count: got %0d want 1", wr_cnt - w0); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_misaligned();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 want earlier end");
        $fatal(1, "watchdog");
    end

endmodule
